// File: rtl/adder_pipe_stage_pkg.sv
// Shared definitions for the adder_pipe_stage slice.
//   WORD_W   : datapath width of the operand/result words
//   OP_ADD   : in_op encoding for A + B + cin
//   OP_SUB   : in_op encoding for A - B (only honoured when ADD_SUB_EN is defined)
//   result_t : adder result bundle carried from the adder to the output stage
package adder_pipe_stage_pkg;

  localparam int   WORD_W = 32;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef struct packed {
    logic              zero;
    logic              of;
    logic              cout;
    logic [WORD_W-1:0] sum;
  } result_t;

endpackage

// File: rtl/adder_pipe_stage_cia.sv
// CarryIncrementAdder: ripple of fixed-size blocks, each block forms its
// operand sum assuming carry-in 0 and then increments that sum by the
// incoming block carry.
// Ports:
//   a, b  in  WIDTH  operands
//   cin   in  1      carry-in
//   sum   out WIDTH  a + b + cin (wraps)
//   cout  out 1      carry-out of the top bit
module CarryIncrementAdder
  import adder_pipe_stage_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int BLK   = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NB = WIDTH / BLK;

  logic [NB:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < NB; i++) begin : g_blk
    logic [BLK:0] raw;
    logic [BLK:0] inc;
    // raw never exceeds 2^(BLK+1)-2, so adding the block carry cannot overflow BLK+1 bits
    assign raw = {1'b0, a[i*BLK +: BLK]} + {1'b0, b[i*BLK +: BLK]};
    assign inc = raw + {{BLK{1'b0}}, carry[i]};
    assign sum[i*BLK +: BLK] = inc[BLK-1:0];
    assign carry[i+1]        = inc[BLK];
  end

  assign cout = carry[NB];

endmodule

// File: rtl/adder_pipe_stage.sv
// adder_pipe_stage: valid/ready pipelined wrapper around CarryIncrementAdder.
// Operands are registered on accept (stage 1), pass through the adder, and the
// sum plus flags are registered for the consumer (stage 2, when REG_OUT=1).
// Parameters:
//   REG_OUT  1: output register present (latency 2); 0: adder drives out_* (latency 1)
// Optional feature macro: ADD_SUB_EN (in_op selects add or subtract).
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready          operand handshake
//   in_a, in_b, in_cin, in_op  operands, carry-in, operation
//   out_valid/out_ready        result handshake
//   out_sum, out_cout          result word and raw adder carry-out
//   out_of, out_zero           signed overflow, result-is-zero
module adder_pipe_stage
  import adder_pipe_stage_pkg::*;
#(
  parameter bit REG_OUT = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_a,
  input  logic [WORD_W-1:0] in_b,
  input  logic              in_cin,
  input  logic              in_op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_sum,
  output logic              out_cout,
  output logic              out_of,
  output logic              out_zero
);

  function automatic logic signed_ovf(input logic signed [WORD_W-1:0] a,
                                      input logic signed [WORD_W-1:0] eb,
                                      input logic signed [WORD_W-1:0] s);
    return ~(a[WORD_W-1] ^ eb[WORD_W-1]) & (a[WORD_W-1] ^ s[WORD_W-1]);
  endfunction

  logic              s1_rdy;
  logic              s2_rdy;
  logic              vld_p1;
  logic [WORD_W-1:0] a_p1;
  logic [WORD_W-1:0] b_p1;
  logic              cin_p1;
  logic [WORD_W-1:0] eb_p1;
  logic              cin_eff_p1;
  logic [WORD_W-1:0] sum_p1;
  logic              cout_p1;
  result_t           res_p1;

  assign s1_rdy   = !vld_p1 || s2_rdy;
  assign in_ready = s1_rdy;

  // ---- stage 1: operand capture ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      a_p1   <= '0;
      b_p1   <= '0;
      cin_p1 <= 1'b0;
    end else if (s1_rdy) begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        a_p1   <= in_a;
        b_p1   <= in_b;
        cin_p1 <= in_cin;
      end
    end
  end

`ifdef ADD_SUB_EN
  logic op_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_p1 <= OP_ADD;
    end else if (s1_rdy && in_valid) begin
      op_p1 <= in_op;
    end
  end

  // subtract as A + ~B + 1; the caller's carry-in is not used for subtract
  assign eb_p1      = (op_p1 == OP_SUB) ? ~b_p1 : b_p1;
  assign cin_eff_p1 = (op_p1 == OP_SUB) ? 1'b1 : cin_p1;
`else
  logic unused_op;

  assign unused_op  = in_op;
  assign eb_p1      = b_p1;
  assign cin_eff_p1 = cin_p1;
`endif

  CarryIncrementAdder #(.WIDTH(WORD_W)) u_cia (
    .a    (a_p1),
    .b    (eb_p1),
    .cin  (cin_eff_p1),
    .sum  (sum_p1),
    .cout (cout_p1)
  );

  assign res_p1.sum  = sum_p1;
  assign res_p1.cout = cout_p1;
  assign res_p1.of   = signed_ovf(a_p1, eb_p1, sum_p1);
  assign res_p1.zero = (sum_p1 == '0);

  // ---- stage 2: result register (or straight-through) ----
  if (REG_OUT) begin : g_reg_out
    logic    vld_p2;
    result_t res_p2;

    assign s2_rdy = !vld_p2 || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_p2 <= 1'b0;
        res_p2 <= '0;
      end else if (s2_rdy) begin
        vld_p2 <= vld_p1;
        if (vld_p1) begin
          res_p2 <= res_p1;
        end
      end
    end

    assign out_valid = vld_p2;
    assign out_sum   = res_p2.sum;
    assign out_cout  = res_p2.cout;
    assign out_of    = res_p2.of;
    assign out_zero  = res_p2.zero;
  end else begin : g_comb_out
    assign s2_rdy    = out_ready;
    assign out_valid = vld_p1;
    assign out_sum   = res_p1.sum;
    assign out_cout  = res_p1.cout;
    assign out_of    = res_p1.of;
    assign out_zero  = res_p1.zero;
  end

endmodule

// File: tb/tb_adder_pipe_stage.sv
// Bench for adder_pipe_stage: index 1 is the REG_OUT=1 instance, index 0 the
// REG_OUT=0 instance. Expected results come from a plain-arithmetic model.
module tb_adder_pipe_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic [31:0] in_a      [2];
  logic [31:0] in_b      [2];
  logic        in_cin    [2];
  logic        in_op     [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic [31:0] out_sum   [2];
  logic        out_cout  [2];
  logic        out_of    [2];
  logic        out_zero  [2];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  adder_pipe_stage #(.REG_OUT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_a(in_a[1]), .in_b(in_b[1]), .in_cin(in_cin[1]), .in_op(in_op[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_sum(out_sum[1]), .out_cout(out_cout[1]), .out_of(out_of[1]), .out_zero(out_zero[1])
  );

  adder_pipe_stage #(.REG_OUT(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_a(in_a[0]), .in_b(in_b[0]), .in_cin(in_cin[0]), .in_op(in_op[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_sum(out_sum[0]), .out_cout(out_cout[0]), .out_of(out_of[0]), .out_zero(out_zero[0])
  );

  // Reference: {zero, of, cout, sum} from integer arithmetic.
  function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic cin, input logic op);
    logic        sub;
    logic [32:0] w;
    logic [31:0] s;
    logic        co;
    longint      sv;
`ifdef ADD_SUB_EN
    sub = op;
`else
    sub = op & 1'b0;
`endif
    if (sub) begin
      s  = a - b;
      co = (a >= b);
      sv = longint'($signed(a)) - longint'($signed(b));
    end else begin
      w  = {1'b0, a} + {1'b0, b} + {32'd0, cin};
      s  = w[31:0];
      co = w[32];
      sv = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
    end
    return {(s == 32'd0), (sv > 64'sd2147483647 || sv < -64'sd2147483648), co, s};
  endfunction

  function automatic logic [31:0] rnd_word();
    case ($urandom_range(0, 5))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h0000_0000;
      default: return $urandom;
    endcase
  endfunction

  // directed add table: a, b, cin, expected {zero, of, cout, sum}
  logic [31:0] ta [5] = '{32'h5, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'hFFFF_FFFE, 32'h8000_0000};
  logic [31:0] tb [5] = '{32'h3, 32'h1,         32'h1,         32'h0,         32'h8000_0000};
  logic        tc [5] = '{1'b0,  1'b0,          1'b0,          1'b1,          1'b0};
  logic [34:0] te [5] = '{{3'b000, 32'h8}, {3'b101, 32'h0}, {3'b010, 32'h8000_0000},
                          {3'b000, 32'hFFFF_FFFF}, {3'b111, 32'h0}};

  task automatic test_reset();
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b0; in_a[d] = '0; in_b[d] = '0; in_cin[d] = 1'b0;
      in_op[d] = 1'b0; out_ready[d] = 1'b1;
    end
    #12;
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (out_valid[d] !== 1'b0) begin
        n_err++; $display("FAIL reset_out_valid d=%0d: got %b want 0", d, out_valid[d]);
      end
      n_cmp++;
      if (in_ready[d] !== 1'b1) begin
        n_err++; $display("FAIL reset_in_ready d=%0d: got %b want 1", d, in_ready[d]);
      end
    end
    n_cmp++;
    if ({out_zero[1], out_of[1], out_cout[1], out_sum[1]} !== 35'd0) begin
      n_err++;
      $display("FAIL reset_out_data: got %h want 0", {out_zero[1], out_of[1], out_cout[1], out_sum[1]});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic(input int d);
    logic [34:0] obs;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      in_valid[d] = 1'b1; in_a[d] = ta[i]; in_b[d] = tb[i]; in_cin[d] = tc[i];
      in_op[d] = 1'b0; out_ready[d] = 1'b1;
      @(posedge clk); #1;
      in_valid[d] = 1'b0;
      @(negedge clk);
      if (d == 1) begin
        n_cmp++;
        if (out_valid[d] !== 1'b0) begin
          n_err++; $display("FAIL basic_latency_early d=%0d row=%0d: got %b want 0", d, i, out_valid[d]);
        end
        @(negedge clk);
      end
      n_cmp++;
      if (out_valid[d] !== 1'b1) begin
        n_err++; $display("FAIL basic_latency d=%0d row=%0d: got %b want 1", d, i, out_valid[d]);
      end
      obs = {out_zero[d], out_of[d], out_cout[d], out_sum[d]};
      n_cmp++;
      if (obs !== te[i]) begin
        n_err++; $display("FAIL basic_result d=%0d row=%0d: got %h want %h", d, i, obs, te[i]);
      end
    end
    @(posedge clk); #1;
  endtask

`ifdef ADD_SUB_EN
  task automatic test_addsub(input int d);
    logic [31:0] sa [5] = '{32'h5, 32'h8000_0000, 32'h7, 32'h5, 32'h1};
    logic [31:0] sb [5] = '{32'h7, 32'h1,         32'h7, 32'h3, 32'h1};
    logic        sc [5] = '{1'b0,  1'b0,          1'b1,  1'b0,  1'b1};
    logic        so [5] = '{1'b1,  1'b1,          1'b1,  1'b1,  1'b0};
    logic [34:0] se [5] = '{{3'b000, 32'hFFFF_FFFE}, {3'b011, 32'h7FFF_FFFF},
                            {3'b101, 32'h0}, {3'b001, 32'h2}, {3'b000, 32'h3}};
    logic [34:0] obs;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      in_valid[d] = 1'b1; in_a[d] = sa[i]; in_b[d] = sb[i]; in_cin[d] = sc[i];
      in_op[d] = so[i]; out_ready[d] = 1'b1;
      @(posedge clk); #1;
      in_valid[d] = 1'b0;
      @(negedge clk);
      if (d == 1) @(negedge clk);
      obs = {out_zero[d], out_of[d], out_cout[d], out_sum[d]};
      n_cmp++;
      if (out_valid[d] !== 1'b1 || obs !== se[i]) begin
        n_err++;
        $display("FAIL addsub d=%0d row=%0d: got v=%b %h want v=1 %h", d, i, out_valid[d], obs, se[i]);
      end
    end
    @(posedge clk); #1;
  endtask
`endif

  task automatic test_stall();
    logic [31:0] sa [3];
    logic [31:0] sb [3];
    logic [34:0] q[$];
    logic [34:0] obs, first;
    int idx = 0;
    int n_out = 0;
    logic acc;
    for (int i = 0; i < 3; i++) begin sa[i] = $urandom; sb[i] = $urandom; end
    @(posedge clk); #1;
    out_ready[1] = 1'b0;
    in_valid[1] = 1'b1; in_a[1] = sa[0]; in_b[1] = sb[0]; in_cin[1] = 1'b0; in_op[1] = 1'b0;
    first = model(sa[0], sb[0], 1'b0, 1'b0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      acc = in_valid[1] && in_ready[1];
      if (c >= 2) begin
        obs = {out_zero[1], out_of[1], out_cout[1], out_sum[1]};
        n_cmp++;
        if (in_ready[1] !== 1'b0 || out_valid[1] !== 1'b1 || obs !== first) begin
          n_err++;
          $display("FAIL stall_hold c=%0d: got rdy=%b v=%b %h want rdy=0 v=1 %h",
                   c, in_ready[1], out_valid[1], obs, first);
        end
      end
      if (acc) q.push_back(model(in_a[1], in_b[1], in_cin[1], in_op[1]));
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        if (idx < 3) begin in_a[1] = sa[idx]; in_b[1] = sb[idx]; end
        else in_valid[1] = 1'b0;
      end
    end
    n_cmp++;
    if (idx !== 2) begin
      n_err++; $display("FAIL stall_accept_count: got %0d want 2", idx);
    end
    out_ready[1] = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      acc = in_valid[1] && in_ready[1];
      if (out_valid[1] && out_ready[1]) begin
        obs = {out_zero[1], out_of[1], out_cout[1], out_sum[1]};
        n_cmp++;
        if (q.size() == 0) begin
          n_err++; $display("FAIL stall_extra_output: got %h want none", obs);
        end else if (obs !== q[0]) begin
          n_err++; $display("FAIL stall_order n=%0d: got %h want %h", n_out, obs, q[0]);
        end
        if (q.size() != 0) void'(q.pop_front());
        n_out++;
      end
      if (acc) q.push_back(model(in_a[1], in_b[1], in_cin[1], in_op[1]));
      @(posedge clk); #1;
      if (acc) begin idx++; in_valid[1] = 1'b0; end
    end
    n_cmp++;
    if (n_out !== 3 || idx !== 3) begin
      n_err++; $display("FAIL stall_none_lost: got out=%0d acc=%0d want out=3 acc=3", n_out, idx);
    end
  endtask

  task automatic test_reset_midflight();
    @(posedge clk); #1;
    out_ready[1] = 1'b0;
    in_valid[1] = 1'b1; in_a[1] = 32'h1; in_b[1] = 32'h2; in_cin[1] = 1'b0; in_op[1] = 1'b0;
    @(posedge clk); #1;
    in_a[1] = 32'h3;
    @(posedge clk); #1;
    in_valid[1] = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid[1] !== 1'b0 || out_sum[1] !== 32'd0) begin
      n_err++; $display("FAIL midreset_clear: got v=%b sum=%h want v=0 sum=0", out_valid[1], out_sum[1]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready[1] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid[1] !== 1'b0 || in_ready[1] !== 1'b1) begin
        n_err++;
        $display("FAIL midreset_stale c=%0d: got v=%b rdy=%b want v=0 rdy=1", c, out_valid[1], in_ready[1]);
      end
    end
  endtask

  task automatic test_random(input int d, input int ncyc);
    logic [34:0] q[$];
    logic [34:0] obs, prev;
    logic prev_stall = 1'b0;
    logic acc;
    logic drain;
    in_valid[d] = 1'b0; out_ready[d] = 1'b1;
    for (int c = 0; c < ncyc + 12; c++) begin
      @(negedge clk);
      obs = {out_zero[d], out_of[d], out_cout[d], out_sum[d]};
      if (prev_stall) begin
        n_cmp++;
        if (out_valid[d] !== 1'b1 || obs !== prev) begin
          n_err++; $display("FAIL rand_stall_stable d=%0d c=%0d: got v=%b %h want v=1 %h",
                            d, c, out_valid[d], obs, prev);
        end
      end
      if (out_valid[d] && out_ready[d]) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_err++; $display("FAIL rand_extra_output d=%0d c=%0d: got %h want none", d, c, obs);
        end else begin
          if (obs !== q[0]) begin
            n_err++; $display("FAIL rand_result d=%0d c=%0d: got %h want %h", d, c, obs, q[0]);
          end
          void'(q.pop_front());
        end
      end
      acc = in_valid[d] && in_ready[d];
      if (acc) q.push_back(model(in_a[d], in_b[d], in_cin[d], in_op[d]));
      prev_stall = out_valid[d] && !out_ready[d];
      prev = obs;
      drain = (c >= ncyc);
      @(posedge clk); #1;
      if (acc || !in_valid[d]) begin
        in_valid[d] = !drain && ($urandom_range(0, 3) != 0);
        in_a[d] = rnd_word(); in_b[d] = rnd_word();
        in_cin[d] = $urandom_range(0, 1); in_op[d] = $urandom_range(0, 1);
      end
      out_ready[d] = drain || ($urandom_range(0, 3) != 0);
    end
    n_cmp++;
    if (q.size() != 0) begin
      n_err++; $display("FAIL rand_drain d=%0d: got %0d pending want 0", d, q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic(1);
    test_basic(0);
`ifdef ADD_SUB_EN
    test_addsub(1);
    test_addsub(0);
`endif
    test_stall();
    test_reset_midflight();
    test_random(1, 400);
    test_random(0, 400);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
